// File: rtl/prv32_mdu.sv
// prv32_mdu: iterative RISC-V M-extension multiply/divide unit, one radix-2 step per cycle.
// Define PRV32_MDU_REM_EN to support REM/REMU; otherwise they finish in one cycle with r=0.
module prv32_mdu #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] r_o
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            sa_q, sa_d;
   logic            sb_q, sb_d;
   logic [XLEN-1:0] bmag_q, bmag_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] r_q, r_d;

   logic            in_sa, in_sb, b_zero, div_ovf, fast;
   logic [XLEN-1:0] amag_in, bmag_in, fast_res;

   // Operand decode for a request presented this cycle.
   always_comb begin
      in_sa   = a_i[XLEN-1] & (op_i == 3'b001 || op_i == 3'b010 || op_i == 3'b100 || op_i == 3'b110);
      in_sb   = b_i[XLEN-1] & (op_i == 3'b001 || op_i == 3'b100 || op_i == 3'b110);
      amag_in = in_sa ? -a_i : a_i;
      bmag_in = in_sb ? -b_i : b_i;
      b_zero  = (b_i == '0);
      div_ovf = ~op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
`ifdef PRV32_MDU_REM_EN
      fast     = op_i[2] & (b_zero | div_ovf);
      fast_res = b_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
`else
      fast     = op_i[2] & (b_zero | div_ovf | op_i[1]);
      fast_res = op_i[1] ? '0 : (b_zero ? '1 : a_i);
`endif
   end

   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN-1:0]   div_trial;
   logic              div_ge;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, fin_res;

   // {hi,lo} is the product accumulator for multiply and {remainder,quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + {1'b0, bmag_q & {XLEN{lo_q[0]}}};
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, bmag_q});
      div_trial = div_shift[XLEN-1:0] - bmag_q;
      prod_s    = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
      quo_s     = (sa_q ^ sb_q) ? -lo_q : lo_q;
      case (op_q)
         3'b000:                 fin_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_res = prod_s[2*XLEN-1:XLEN];
`ifdef PRV32_MDU_REM_EN
         3'b110, 3'b111:         fin_res = sa_q ? -hi_q : hi_q;
`endif
         default:                fin_res = quo_s;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      bmag_d  = bmag_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      r_d     = r_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start_i && !kill_i) begin
               op_d   = op_i;
               sa_d   = in_sa;
               sb_d   = in_sb;
               bmag_d = bmag_in;
               hi_d   = '0;
               lo_d   = amag_in;
               cnt_d  = '0;
               if (fast) begin
                  r_d     = fast_res;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (op_q[2]) begin
               hi_d = div_ge ? div_trial : div_shift[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], div_ge};
            end else begin
               hi_d = mul_sum[XLEN:1];
               lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
               cnt_d   = '0;
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            r_d     = fin_res;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      // A flush abandons the operation and leaves the last result visible.
      if (kill_i) begin
         state_d = S_IDLE;
         r_d     = r_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bmag_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bmag_q  <= bmag_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         r_q     <= r_d;
      end
   end

   assign busy_o = (state_q == S_CALC) || (state_q == S_FIN);
   assign done_o = (state_q == S_DONE);
   assign r_o    = r_q;

endmodule

// File: tb/tb_prv32_mdu.sv
// Bench for prv32_mdu: directed XLEN=32 cases plus random sweeps at XLEN=8 and 32 against a reference model.
module tb_prv32_mdu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        s32_start = 1'b0, s32_kill = 1'b0, s32_busy, s32_done;
   logic [2:0]  s32_op = '0;
   logic [31:0] s32_a = '0, s32_b = '0, s32_r;

   logic        s8_start = 1'b0, s8_kill = 1'b0, s8_busy, s8_done;
   logic [2:0]  s8_op = '0;
   logic [7:0]  s8_a = '0, s8_b = '0, s8_r;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prv32_mdu #(.XLEN(32)) u32 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(s32_start), .kill_i(s32_kill),
      .op_i(s32_op), .a_i(s32_a), .b_i(s32_b),
      .busy_o(s32_busy), .done_o(s32_done), .r_o(s32_r)
   );

   prv32_mdu #(.XLEN(8)) u8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(s8_start), .kill_i(s8_kill),
      .op_i(s8_op), .a_i(s8_a), .b_i(s8_b),
      .busy_o(s8_busy), .done_o(s8_done), .r_o(s8_r)
   );

   // Reference result straight from the M-extension definitions, using 64-bit integer arithmetic.
   function automatic logic [63:0] ref_mdu(input int w, input logic [2:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask;
      longint ua, ub, as_, bs_, opa, opb, p, q, rm;
      mask = (64'd1 << w) - 64'd1;
      ua  = longint'(a & mask);
      ub  = longint'(b & mask);
      as_ = a[w-1] ? ua - (longint'(1) << w) : ua;
      bs_ = b[w-1] ? ub - (longint'(1) << w) : ub;
      if (!op[2]) begin
         opa = (op == 3'b001 || op == 3'b010) ? as_ : ua;
         opb = (op == 3'b001) ? bs_ : ub;
         p   = opa * opb;
         if (op == 3'b000) return 64'(p) & mask;
         return (64'(p) >> w) & mask;
      end
      if (ub == 0) begin
         q  = -1;
         rm = ua;
      end else if (!op[0]) begin
         q  = as_ / bs_;
         rm = as_ % bs_;
      end else begin
         q  = ua / ub;
         rm = ua % ub;
      end
      if (!op[1]) return 64'(q) & mask;
`ifdef PRV32_MDU_REM_EN
      return 64'(rm) & mask;
`else
      return 64'd0;
`endif
   endfunction

   // Start-to-done cycles: one for the early-out division cases, XLEN+2 otherwise.
   function automatic int ref_lat(input int w, input logic [2:0] op,
                                  input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      if (!op[2]) return w + 2;
      if ((b & mask) == 0) return 1;
      if (!op[0] && (a & mask) == (64'd1 << (w - 1)) && (b & mask) == mask) return 1;
`ifndef PRV32_MDU_REM_EN
      if (op[1]) return 1;
`endif
      return w + 2;
   endfunction

   function automatic logic [63:0] pick(input int w);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1 << (w - 1);
         2: return mask;
         3: return 64'd1;
         default: return {32'd0, $urandom} & mask;
      endcase
   endfunction

   // Issues one request (start high in the current cycle), scrambles the inputs while
   // the unit works, and returns the result and the start-to-done cycle count.
   task automatic run_op(input bit w8, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] r, output int lat);
      if (w8) begin
         s8_op = op; s8_a = a[7:0]; s8_b = b[7:0]; s8_start = 1'b1;
      end else begin
         s32_op = op; s32_a = a[31:0]; s32_b = b[31:0]; s32_start = 1'b1;
      end
      @(posedge clk); #1;
      s8_start = 1'b0;
      s32_start = 1'b0;
      lat = 1;
      while (!(w8 ? s8_done : s32_done) && lat < 200) begin
         if (w8) begin
            s8_a = 8'($urandom); s8_b = 8'($urandom); s8_op = 3'($urandom);
         end else begin
            s32_a = $urandom; s32_b = $urandom; s32_op = 3'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      r = w8 ? {56'd0, s8_r} : {32'd0, s32_r};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s32_start = 1'b1; s32_op = 3'b000; s32_a = 32'd3; s32_b = 32'd4;
      repeat (3) @(posedge clk);
      #1;
      s32_start = 1'b0;
      vectors++; if (s32_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy32 got=%b want=0", s32_busy); end
      vectors++; if (s32_done !== 1'b0) begin miscompares++; $display("FAIL reset_done32 got=%b want=0", s32_done); end
      vectors++; if (s32_r !== 32'd0) begin miscompares++; $display("FAIL reset_r32 got=%h want=0", s32_r); end
      vectors++; if (s8_busy !== 1'b0 || s8_done !== 1'b0 || s8_r !== 8'd0) begin
         miscompares++; $display("FAIL reset_8 busy=%b done=%b r=%h want 0/0/00", s8_busy, s8_done, s8_r);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      logic [63:0] r;
      int lat;
      run_op(1'b0, 3'b001, 64'h8000_0000, 64'h8000_0000, r, lat);
      vectors++; if (r !== 64'h4000_0000) begin miscompares++; $display("FAIL mulh_min r=%h want=40000000", r); end
      vectors++; if (lat != 34) begin miscompares++; $display("FAIL mulh_lat got=%0d want=34", lat); end
      @(posedge clk); #1;
      vectors++; if (s32_done !== 1'b0 || s32_busy !== 1'b0) begin
         miscompares++; $display("FAIL done_pulse done=%b busy=%b want 0/0", s32_done, s32_busy);
      end
      run_op(1'b0, 3'b000, 64'd7, 64'hFFFF_FFFD, r, lat);
      vectors++; if (r !== 64'hFFFF_FFEB) begin miscompares++; $display("FAIL mul_7_m3 r=%h want=ffffffeb", r); end
      run_op(1'b0, 3'b000, 64'h1234_5678, 64'd0, r, lat);
      vectors++; if (r !== 64'd0 || lat != 34) begin
         miscompares++; $display("FAIL mul_b0 r=%h lat=%0d want 0/34", r, lat);
      end
   endtask

   task automatic test_div();
      logic [63:0] r;
      int lat;
      run_op(1'b0, 3'b100, 64'hFFFF_FFF9, 64'd2, r, lat);
      vectors++; if (r !== 64'hFFFF_FFFD) begin miscompares++; $display("FAIL div_m7_2 r=%h want=fffffffd", r); end
      vectors++; if (lat != 34) begin miscompares++; $display("FAIL div_lat got=%0d want=34", lat); end
`ifdef PRV32_MDU_REM_EN
      run_op(1'b0, 3'b110, 64'hFFFF_FFF9, 64'd2, r, lat);
      vectors++; if (r !== 64'hFFFF_FFFF || lat != 34) begin
         miscompares++; $display("FAIL rem_m7_2 r=%h lat=%0d want ffffffff/34", r, lat);
      end
`else
      run_op(1'b0, 3'b110, 64'd9, 64'd4, r, lat);
      vectors++; if (r !== 64'd0 || lat != 1) begin
         miscompares++; $display("FAIL rem_disabled r=%h lat=%0d want 0/1", r, lat);
      end
`endif
   endtask

   task automatic test_fast_path();
      logic [63:0] r;
      int lat;
      run_op(1'b0, 3'b101, 64'd5, 64'd0, r, lat);
      vectors++; if (r !== 64'hFFFF_FFFF || lat != 1) begin
         miscompares++; $display("FAIL divu_by0 r=%h lat=%0d want ffffffff/1", r, lat);
      end
      run_op(1'b0, 3'b111, 64'd5, 64'd0, r, lat);
`ifdef PRV32_MDU_REM_EN
      vectors++; if (r !== 64'd5 || lat != 1) begin
         miscompares++; $display("FAIL remu_by0 r=%h lat=%0d want 5/1", r, lat);
      end
`else
      vectors++; if (r !== 64'd0 || lat != 1) begin
         miscompares++; $display("FAIL remu_by0 r=%h lat=%0d want 0/1", r, lat);
      end
`endif
      run_op(1'b0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, r, lat);
      vectors++; if (r !== 64'h8000_0000 || lat != 1) begin
         miscompares++; $display("FAIL div_ovf r=%h lat=%0d want 80000000/1", r, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r;
      int lat;
      run_op(1'b0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, lat);
      vectors++; if (r !== 64'hFFFF_FFFE) begin miscompares++; $display("FAIL mulhu_ones r=%h want=fffffffe", r); end
      // issued during the DONE cycle of the previous op
      run_op(1'b0, 3'b010, 64'hFFFF_FFFF, 64'd2, r, lat);
      vectors++; if (r !== 64'hFFFF_FFFF || lat != 34) begin
         miscompares++; $display("FAIL b2b_mulhsu r=%h lat=%0d want ffffffff/34", r, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_busy_ignore();
      int lat;
      s32_op = 3'b000; s32_a = 32'd1000; s32_b = 32'd3; s32_start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      for (int c = 1; c <= 20; c++) begin
         s32_start = c[0];
         s32_a = $urandom; s32_b = $urandom; s32_op = 3'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      s32_start = 1'b0;
      while (!s32_done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      vectors++; if (s32_r !== 32'd3000 || lat != 34) begin
         miscompares++; $display("FAIL busy_ignore r=%h lat=%0d want 00000bb8/34", s32_r, lat);
      end
      @(posedge clk); #1;
      vectors++; if (s32_busy !== 1'b0 || s32_done !== 1'b0) begin
         miscompares++; $display("FAIL busy_ignore_idle busy=%b done=%b want 0/0", s32_busy, s32_done);
      end
   endtask

   task automatic test_kill();
      logic [63:0] r;
      int lat;
      bit seen;
      run_op(1'b0, 3'b101, 64'd100, 64'd7, r, lat);
      vectors++; if (r !== 64'd14) begin miscompares++; $display("FAIL divu_100_7 r=%h want=0000000e", r); end
      @(posedge clk); #1;
      s32_op = 3'b100; s32_a = 32'hFFFF_FF9C; s32_b = 32'd3; s32_start = 1'b1;
      @(posedge clk); #1;
      s32_start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      s32_kill = 1'b1;
      @(posedge clk); #1;
      s32_kill = 1'b0;
      vectors++; if (s32_busy !== 1'b0 || s32_done !== 1'b0) begin
         miscompares++; $display("FAIL kill_busy busy=%b done=%b want 0/0", s32_busy, s32_done);
      end
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (s32_done) seen = 1'b1;
         @(posedge clk); #1;
      end
      vectors++; if (seen || s32_r !== 32'd14) begin
         miscompares++; $display("FAIL kill_nodone done_seen=%b r=%h want 0/0000000e", seen, s32_r);
      end
      s32_start = 1'b1; s32_kill = 1'b1;
      @(posedge clk); #1;
      s32_start = 1'b0; s32_kill = 1'b0;
      vectors++; if (s32_busy !== 1'b0 || s32_done !== 1'b0) begin
         miscompares++; $display("FAIL kill_start busy=%b done=%b want 0/0", s32_busy, s32_done);
      end
      run_op(1'b0, 3'b100, 64'hFFFF_FF9C, 64'd3, r, lat);
      vectors++; if (r !== 64'hFFFF_FFDF || lat != 34) begin
         miscompares++; $display("FAIL after_kill r=%h lat=%0d want ffffffdf/34", r, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [63:0] r;
      int lat;
      run_op(1'b0, 3'b000, 64'd6, 64'd7, r, lat);
      vectors++; if (r !== 64'd42) begin miscompares++; $display("FAIL mul_6_7 r=%h want=0000002a", r); end
      s32_op = 3'b000; s32_a = 32'd9; s32_b = 32'd9; s32_start = 1'b1;
      @(posedge clk); #1;
      s32_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      vectors++; if (s32_busy !== 1'b0 || s32_done !== 1'b0 || s32_r !== 32'd0) begin
         miscompares++; $display("FAIL reset_mid busy=%b done=%b r=%h want 0/0/0", s32_busy, s32_done, s32_r);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random(input bit w8, input int n);
      logic [63:0] r, a, b, exp_r;
      logic [2:0]  op;
      int lat, exp_l, w;
      w = w8 ? 8 : 32;
      for (int i = 0; i < n; i++) begin
         op = 3'($urandom);
         a = pick(w);
         b = pick(w);
         exp_r = ref_mdu(w, op, a, b);
         exp_l = ref_lat(w, op, a, b);
         run_op(w8, op, a, b, r, lat);
         vectors++; if (r !== exp_r) begin
            miscompares++; $display("FAIL rand%0d_r op=%0d a=%h b=%h got=%h want=%h", w, op, a, b, r, exp_r);
         end
         vectors++; if (lat != exp_l) begin
            miscompares++; $display("FAIL rand%0d_lat op=%0d a=%h b=%h got=%0d want=%0d", w, op, a, b, lat, exp_l);
         end
         if ($urandom_range(0, 1) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_fast_path();
      test_back_to_back();
      test_busy_ignore();
      test_kill();
      test_reset_mid();
      test_random(1'b1, 400);
      test_random(1'b0, 60);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
